univ_shift_reg: RTL
===================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001: Parameter WIDTH, default 8, sets the register width in bits; legal range is 2 to 64.
REQ-002: Parameter ROTATE, default 0; 0 selects shift mode, 1 selects rotate mode.
REQ-003: Local constant CW = $clog2(WIDTH+1) SHALL set the counter width.
REQ-004: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: en  input  1  clock enable; when low, all state holds.
REQ-007: mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008: sin  input  1  serial input bit.
REQ-009: d  input  WIDTH  parallel load data.
REQ-010: q  output  WIDTH  registered register contents.
REQ-011: sout  output  1  registered; the bit most recently shifted out.
REQ-012: count  output  CW  registered number of shifts since the last load or reset, saturating.
REQ-013: full  output  1  combinational; high when count == WIDTH.
REQ-014: done  output  1  registered one-cycle pulse.

Function
REQ-015: With en=1 and mode=11, the block SHALL set q <= d and count <= 0; sout and done SHALL stay 0.
REQ-016: With en=1 and mode=01 (shift right), the block SHALL set q <= {in_bit, q[WIDTH-1:1]} and sout <= q[0].
REQ-017: With en=1 and mode=10 (shift left), the block SHALL set q <= {q[WIDTH-2:0], in_bit} and sout <= q[WIDTH-1].
REQ-018: in_bit SHALL be sin when ROTATE=0; when ROTATE=1 it SHALL be the bit being shifted out, and sin is ignored.
REQ-019: On each shift, count SHALL increment by 1 and saturate at WIDTH; it SHALL never wrap to 0.
REQ-020: done SHALL be 1 for exactly the one cycle after the edge on which count goes from WIDTH-1 to WIDTH; otherwise done SHALL be 0.
REQ-021: With mode=00, or with en=0 in any mode, q, sout and count SHALL hold and done SHALL be 0 on that edge.
REQ-022: A shift at saturation SHALL update q and sout, SHALL keep count at WIDTH, and SHALL NOT reassert done.
REQ-023: A load at saturation SHALL clear count and deassert full on the following cycle.
REQ-024: A mode change between shift right and shift left SHALL NOT reset count; count keeps accumulating.
REQ-025: All outputs SHALL be glitch-free registered values, except full, which is a decode of count only.
REQ-026: Latency from d/sin to q SHALL be one clock edge; there SHALL be no transparent (latch) path from inputs to q.

Reset
REQ-027: While rst=1, independent of clk, the block SHALL hold q=0, sout=0, count=0, done=0 and full=0.
REQ-028: Assertion of rst in the middle of a shift sequence SHALL discard that sequence; after release, count restarts from 0.
REQ-029: Inputs sampled on the first rising edge after rst deasserts SHALL take effect normally.

Verification (WIDTH=8)
REQ-030: Load d=8'hA5, then hold q=A5 and pulse rst between edges -> q=00 and count=0 immediately, before the next edge.
REQ-031: ROTATE=0: load A5, then 8 right shifts with sin=1 -> sout sequence 1,0,1,0,0,1,0,1; final q=FF; done high for one cycle after the 8th edge; full=1.
REQ-032: ROTATE=0: load 8'h81, then one left shift with sin=0 -> q=02, sout=1, count=1.
REQ-033: ROTATE=1: load 8'h81, then one right shift with sin=0 -> q=C0, sout=1; after 8 shifts total -> q=81.
REQ-034: With en=0 and mode=11, d=3C held for 3 edges -> q, sout and count unchanged, done=0.
REQ-035: A 9th right shift with sin=0 after REQ-031 -> q=7F, count stays 8, done stays 0; a following load 00 -> count=0, full=0.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Bundle of control, data and status signals for the universal shift register.
// The master side drives the operation controls and observes register state;
// the slave side is the shift register itself.
interface univ_shift_reg_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [1:0]       mode;
   logic             sin;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic [CW-1:0]    count;
   logic             full;
   logic             done;

   modport master (
      output en, mode, sin, d,
      input  q, sout, count, full, done
   );

   modport slave (
      input  en, mode, sin, d,
      output q, sout, count, full, done
   );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with optional rotate, a saturating shift counter and a one-cycle pulse when
// the counter first reaches WIDTH after a load or reset.
module univ_shift_reg #(
   parameter int WIDTH  = 8,
   parameter bit ROTATE = 1'b0
) (
   input logic             clk,
   input logic             rst,
   univ_shift_reg_if.slave bus
);
   localparam int            CW    = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] C_SAT = CW'(WIDTH);
   localparam logic [CW-1:0] C_PRE = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_q;
   logic             r_sout;
   logic [CW-1:0]    r_count;
   logic             r_done;

   logic             w_load;
   logic             w_shr;
   logic             w_shl;
   logic             w_shift;
   logic             w_out_bit;
   logic             w_in_bit;
   logic [WIDTH-1:0] w_q_shifted;

   // Decode the enabled operation and form the shifted register image
   always_comb begin
      w_load      = bus.en && (bus.mode == 2'b11);
      w_shr       = bus.en && (bus.mode == 2'b01);
      w_shl       = bus.en && (bus.mode == 2'b10);
      w_shift     = w_shr || w_shl;
      // Bit leaving the register: MSB for a left shift, LSB otherwise
      w_out_bit   = w_shl ? r_q[WIDTH-1] : r_q[0];
      // In rotate mode the departing bit wraps around and sin is ignored
      w_in_bit    = ROTATE ? w_out_bit : bus.sin;
      w_q_shifted = w_shl ? {r_q[WIDTH-2:0], w_in_bit}
                          : {w_in_bit, r_q[WIDTH-1:1]};
   end

   // Register contents, last shifted-out bit, saturating count and done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q     <= '0;
         r_sout  <= 1'b0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         // done is a single-cycle pulse; every edge that is not the
         // WIDTH-1 -> WIDTH transition drops it
         r_done <= 1'b0;
         if (w_load) begin
            r_q     <= bus.d;
            r_sout  <= 1'b0;
            r_count <= '0;
         end else if (w_shift) begin
            r_q    <= w_q_shifted;
            r_sout <= w_out_bit;
            if (r_count != C_SAT) begin
               r_count <= r_count + CW'(1);
            end
            // Only the increment into saturation fires done, so shifting
            // while already saturated never re-triggers it
            r_done <= (r_count == C_PRE);
         end
      end
   end

   assign bus.q     = r_q;
   assign bus.sout  = r_sout;
   assign bus.count = r_count;
   assign bus.done  = r_done;
   // full is a pure decode of the registered count
   assign bus.full  = (r_count == C_SAT);
endmodule
